// File: rtl/seq_mult4.sv
// seq_mult4: 4x4 unsigned shift-and-add multiplier sequencing an external combinational 4-bit adder.
module seq_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mcand,
  input  logic [3:0] mplier,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_ci,
  input  logic [3:0] add_s,
  input  logic       add_co,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] m_q, m_d, p_hi_q, p_hi_d, q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic [7:0] shifted;
  assign add_a   = p_hi_q;
  assign add_b   = (state_q == RUN && q_q[0]) ? m_q : 4'd0;
  assign add_ci  = 1'b0;
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign product = product_q;
  // add-or-not already folded into the adder result; this is the right shift
  assign shifted = {add_co, add_s, q_q[3:1]};
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_hi_d    = p_hi_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q != RUN && start) begin
      m_d     = mcand;
      q_d     = mplier;
      p_hi_d  = 4'd0;
      cnt_d   = 2'd0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      {p_hi_d, q_d} = shifted;
      cnt_d         = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        product_d = shifted;
        state_d   = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= 4'd0;
      p_hi_q    <= 4'd0;
      q_q       <= 4'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_hi_q    <= p_hi_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_seq_mult4.sv
// tb_seq_mult4: directed and exhaustive checks of seq_mult4 driving a behavioural adder.
module tb_seq_mult4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] mcand = 4'd0, mplier = 4'd0;
  logic [3:0] add_a, add_b, add_s;
  logic       add_ci, add_co, busy, done;
  logic [7:0] product;
  int         n_chk = 0, n_pass = 0, cyc = 0;

  seq_mult4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .busy(busy), .done(done), .product(product)
  );

  assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts a start, then runs until done (bounded); returns positioned in the DONE cycle.
  task automatic run_mult(input logic [3:0] a, input logic [3:0] b, output logic [15:0] bseq,
                          output int busy_n, output logic done_seen, output logic [7:0] prod);
    start = 1'b1; mcand = a; mplier = b;
    step();
    start = 1'b0;
    bseq = 16'd0; busy_n = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) begin bseq = {bseq[11:0], add_b}; busy_n++; end
      step();
    end
    done_seen = done; prod = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); mcand = 4'($urandom); mplier = 4'($urandom);
      step();
    end
    n_chk++; if (product !== 8'h00) $display("FAIL reset_product got %h want 00", product); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_chk++; if (add_a !== 4'h0 || add_b !== 4'h0 || add_ci !== 1'b0)
      $display("FAIL reset_adder got a=%h b=%h ci=%b want 0 0 0", add_a, add_b, add_ci); else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    step();
    n_chk++; if (busy !== 1'b0) $display("FAIL idle_after_reset busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_15x15();
    logic [15:0] bs; int bn; logic ds; logic [7:0] p;
    run_mult(4'hF, 4'hF, bs, bn, ds, p);
    n_chk++; if (bn != 4) $display("FAIL 15x15_busy_cycles got %0d want 4", bn); else n_pass++;
    n_chk++; if (ds !== 1'b1) $display("FAIL 15x15_done got %b want 1", ds); else n_pass++;
    n_chk++; if (p !== 8'hE1) $display("FAIL 15x15_product got %h want e1", p); else n_pass++;
    n_chk++; if (bs !== 16'hFFFF) $display("FAIL 15x15_add_b got %h want ffff", bs); else n_pass++;
    step();
    n_chk++; if (done !== 1'b0) $display("FAIL 15x15_done_width done=%b want 0", done); else n_pass++;
    n_chk++; if (product !== 8'hE1) $display("FAIL 15x15_product_hold got %h want e1", product); else n_pass++;
  endtask

  task automatic test_13x11();
    logic [15:0] bs; int bn; logic ds; logic [7:0] p;
    run_mult(4'hD, 4'hB, bs, bn, ds, p);
    n_chk++; if (p !== 8'h8F) $display("FAIL 13x11_product got %h want 8f", p); else n_pass++;
    n_chk++; if (bs !== 16'hDD0D) $display("FAIL 13x11_add_b got %h want dd0d", bs); else n_pass++;
    step();
    run_mult(4'h0, 4'h9, bs, bn, ds, p);
    n_chk++; if (p !== 8'h00) $display("FAIL 0x9_product got %h want 00", p); else n_pass++;
    n_chk++; if (bn != 4 || ds !== 1'b1) $display("FAIL 0x9_latency got %0d done=%b want 4 1", bn, ds); else n_pass++;
    step();
  endtask

  task automatic test_ignored_start();
    start = 1'b1; mcand = 4'h2; mplier = 4'h3;
    step();
    start = 1'b0;
    step();
    start = 1'b1; mcand = 4'hF; mplier = 4'hF;
    step();
    n_chk++; if (add_b !== 4'h0 || busy !== 1'b1) $display("FAIL ignored_mid add_b=%h busy=%b want 0 1", add_b, busy); else n_pass++;
    step();
    start = 1'b0;
    step();
    n_chk++; if (done !== 1'b1 || product !== 8'h06)
      $display("FAIL ignored_result done=%b product=%h want 1 06", done, product); else n_pass++;
    step();
    step();
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignored_no_extra busy=%b done=%b want 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c1 = 0, c2 = 0;
    start = 1'b1; mcand = 4'h3; mplier = 4'h5;
    step();
    for (int i = 0; i < 20 && !done; i++) step();
    c1 = cyc;
    n_chk++; if (done !== 1'b1 || product !== 8'h0F) $display("FAIL b2b_first done=%b product=%h want 1 0f", done, product); else n_pass++;
    mcand = 4'h7; mplier = 4'h9;
    step();
    for (int i = 0; i < 20 && !done; i++) step();
    c2 = cyc;
    n_chk++; if (done !== 1'b1 || product !== 8'h3F) $display("FAIL b2b_second done=%b product=%h want 1 3f", done, product); else n_pass++;
    n_chk++; if (c2 - c1 != 5) $display("FAIL b2b_spacing got %0d want 5", c2 - c1); else n_pass++;
    mcand = 4'h9; mplier = 4'h9;
    step();
    step();
    start = 1'b0;
    n_chk++; if (busy !== 1'b1 || add_a !== 4'h4) $display("FAIL pre_reset busy=%b add_a=%h want 1 4", busy, add_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 || add_a !== 4'h0 || add_b !== 4'h0)
      $display("FAIL async_clear busy=%b done=%b product=%h a=%h b=%h want 0 0 00 0 0", busy, done, product, add_a, add_b);
    else n_pass++;
    step();
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin step(); seen |= done | busy; end
      n_chk++; if (seen !== 1'b0) $display("FAIL post_reset_idle activity=%b want 0", seen); else n_pass++;
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] bs; int bn; logic ds; logic [7:0] p; int bad = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        run_mult(4'(a), 4'(b), bs, bn, ds, p);
        n_chk++;
        if (p !== 8'(a * b) || ds !== 1'b1) begin
          bad++;
          if (bad < 10) $display("FAIL exhaustive %0dx%0d got %h want %h", a, b, p, 8'(a * b));
        end else n_pass++;
      end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_15x15();
    test_13x11();
    test_ignored_start();
    test_back_to_back();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_mult4.md
# seq_mult4

Sequential 4x4 unsigned shift-and-add multiplier that drives the 4-bit ripple-carry `adder` stage. It feeds that adder its operands and carry-in, then consumes the sum and carry-out one step per clock. After four steps it presents an 8-bit product. The adder stays purely combinational; this block owns all state, sequencing and handshaking.

## Interface
- No parameters. Width is fixed at 4x4 -> 8, matching the adder.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin a multiply; sampled on the rising edge.
- `mcand`  in  4  multiplicand, unsigned; captured when `start` is accepted.
- `mplier`  in  4  multiplier, unsigned; captured when `start` is accepted.
- `add_a`  out  4  adder operand a, combinational from state: = `P_hi`.
- `add_b`  out  4  adder operand b, combinational from state: = `M` when state is RUN and `Q[0]`=1, else 0.
- `add_ci`  out  1  adder carry-in; constant 0.
- `add_s`  in  4  adder sum, returned in the same cycle.
- `add_co`  in  1  adder carry-out, returned in the same cycle.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  high for exactly one cycle, when state is DONE.
- `product`  out  8  last completed product; held until the next completion.

## Operation
- Internal registers:
  - `M[3:0]`: captured multiplicand.
  - `P_hi[3:0]`: partial-product upper half.
  - `Q[3:0]`: multiplier being shifted out, and the product lower half.
  - `cnt[1:0]`: step counter.
  - `state`: one of IDLE, RUN, DONE.
- IDLE:
  - If `start`=1: `M`<=`mcand`, `Q`<=`mplier`, `P_hi`<=0, `cnt`<=0, state -> RUN.
  - Otherwise hold.
- RUN, each cycle:
  - Update: `{P_hi, Q}` <= `{add_co, add_s, Q[3:1]}`. This is add-or-not, then shift right by one, using the adder result.
  - `cnt` increments each RUN cycle.
  - When `cnt`=3, the same edge also loads `product` <= `{add_co, add_s, Q[3:1]}` and moves state -> DONE.
- DONE:
  - `done`=1 for this cycle.
  - If `start`=1: accepted exactly as in IDLE, state -> RUN. Back-to-back operation is supported.
  - Otherwise state -> IDLE.
- `start` is ignored while state is RUN. Operands at that time have no effect.
- `mcand` and `mplier` may change freely after the accepting edge.
- Arithmetic: `P_hi` + (`M` or 0) never exceeds 15+15 = 30 < 32, so the 5-bit `{add_co, add_s}` never loses information. The final product is at most 225 (0xE1).
- Zero operands take no shortcut: latency is always 4 RUN cycles.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate): state=IDLE, `M`=`P_hi`=`Q`=0, `cnt`=0.
- Outputs while in reset: `product`=0x00, `busy`=0, `done`=0, `add_a`=0, `add_b`=0, `add_ci`=0.
- Latency for `start` accepted at edge E0:
  - `busy`=1 during cycles E0..E4.
  - Steps execute at edges E1..E4.
  - `product` is valid, and `done`=1, in the cycle after E4.
  - Start to done is 5 edges.
- Throughput: one multiply per 5 cycles when `start` is held high.
- `product` changes only at the E4 edge of a completing operation.
- Reset asserted mid-RUN: the operation is abandoned, all registers are cleared, and no `done` is issued. After `rst_n` deasserts, the block waits in IDLE for `start`.
- The adder path is combinational: state -> `add_a`/`add_b` -> adder -> `add_s`/`add_co` -> registers. It must close within one clock period.

## Test plan
- Reset: hold `rst_n`=0 with random inputs.
  - Required: `product`=0x00, `busy`=0, `done`=0, `add_a`=`add_b`=0.
- 15x15: `mcand`=0xF, `mplier`=0xF, pulse `start`.
  - Required: `busy` high for 4 cycles, then `done`=1 for one cycle, `product`=0xE1.
  - Required: `add_b`=0xF on every RUN cycle.
- 13x11:
  - Required: product 0x8F (143).
  - Required: `add_b` sequence 0xD, 0xD, 0x0, 0xD.
  - Then 0x0 x 0x9: required product 0x00, still after 4 RUN cycles.
- Ignored start: assert `start` with new operands during RUN.
  - Required: the original result completes unchanged and no extra operation begins.
- Back-to-back and reset: hold `start`=1 with a new operand pair each done.
  - Required: 3x5 -> 0x0F, then 7x9 -> 0x3F; `done` pulses 5 cycles apart.
  - Then drop `rst_n` at RUN cycle 2. Required: immediate clear, no `done`.
- Exhaustive: all 256 operand pairs, driven through a behavioural model of `adder`.
  - Required: `product` == `mcand`*`mplier` for every pair.
